noc_inject_scheduler: RTL

NOC_INJECT_SCHEDULER -- requirements
Module: noc_inject_scheduler

---
 rtl/noc_inject_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/noc_inject_scheduler.sv
// Injection scheduler for one mesh node: round-robin arbitration over local requesters,
// per-destination credit limits, X-first packet formatting and a one-entry output register.
module noc_inject_scheduler #(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned WIDTH        = 13 + 5 * FILTER_WIDTH,
  parameter int unsigned NREQ         = 3,
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned SRC_NODE     = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [4*NREQ-1:0]                req_dest,
  input  logic [NREQ-1:0]                  req_type,
  input  logic [5*FILTER_WIDTH*NREQ-1:0]   req_data,
  output logic                             pkt_valid,
  input  logic                             pkt_ready,
  output logic [WIDTH-1:0]                 pkt_data,
  input  logic                             ack_valid,
  input  logic [3:0]                       ack_node,
  output logic                             ack_ready,
  output logic                             busy,
  output logic [15:0]                      pkt_count,
  output logic                             err_bad_dest,
  output logic                             err_ack_underflow
);

  localparam int unsigned PAY_W  = 5 * FILTER_WIDTH;
  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CRED_W = 2;
  localparam int unsigned NNODE  = 16;
  localparam int unsigned OUT_NODE = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [CRED_W-1:0]   credit [NNODE];
  logic [NREQ-1:0]     eligible;
  logic                grant_found;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    cand;
  logic                space;
  logic                grant;
  logic                good_grant;
  logic                g_bad;
  logic [3:0]          g_dest;
  logic [WIDTH-1:0]    pkt_fmt;
  logic                load_pkt;
  logic                count_inc;
  logic [NNODE-1:0]    cred_inc;
  logic [NNODE-1:0]    cred_dec;
  logic [NNODE-1:0]    cred_nz;
  logic                ack_underflow;

  function automatic logic [2:0] therm(input logic [1:0] hops);
    case (hops)
      2'd0:    therm = 3'b000;
      2'd1:    therm = 3'b100;
      2'd2:    therm = 3'b110;
      default: therm = 3'b111;
    endcase
  endfunction

  // A requester competes only if enabled and its destination has credit left.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = en & req_valid[i] &
                    (credit[req_dest[4*i +: 4]] < CRED_W'(MAX_OUT));
    end
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    space      = (state == ST_EMPTY) | pkt_ready;
    grant      = grant_found & space;
    g_dest     = req_dest[4*grant_idx +: 4];
    g_bad      = (g_dest == 4'(SRC_NODE)) | (g_dest == 4'(OUT_NODE));
    good_grant = grant & ~g_bad;
    pkt_fmt    = WIDTH'({req_data[PAY_W*grant_idx +: PAY_W], req_type[grant_idx], 2'b01,
                         therm(2'd3 - g_dest[3:2]), therm(g_dest[1:0]), g_dest});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (good_grant) state_nxt = ST_HOLD;
      ST_HOLD:  if (pkt_ready && !good_grant) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    req_ready = '0;
    load_pkt  = 1'b0;
    count_inc = 1'b0;
    if (grant) req_ready[grant_idx] = 1'b1;
    load_pkt  = good_grant;
    count_inc = (state == ST_HOLD) & pkt_ready;
  end

  assign pkt_valid = (state == ST_HOLD);
  assign ack_ready = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_data          <= '0;
      rr_ptr            <= '0;
      pkt_count         <= '0;
      err_bad_dest      <= 1'b0;
      err_ack_underflow <= 1'b0;
    end else begin
      if (load_pkt)  pkt_data  <= pkt_fmt;
      if (count_inc) pkt_count <= pkt_count + 16'd1;
      if (grant) begin
        rr_ptr <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      if (grant && g_bad) err_bad_dest      <= 1'b1;
      if (ack_underflow)  err_ack_underflow <= 1'b1;
    end
  end

  // A grant and a valid ack on the same node cancel; an ack at zero credit is discarded.
  always_comb begin
    ack_underflow = ack_valid & (credit[ack_node] == '0);
    for (int n = 0; n < NNODE; n++) begin
      cred_inc[n] = good_grant & (g_dest == 4'(n));
      cred_dec[n] = ack_valid & (ack_node == 4'(n)) & (credit[n] != '0);
      cred_nz[n]  = (credit[n] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NNODE; n++) credit[n] <= '0;
    end else begin
      for (int n = 0; n < NNODE; n++) begin
        if (cred_inc[n] && !cred_dec[n])      credit[n] <= credit[n] + CRED_W'(1);
        else if (cred_dec[n] && !cred_inc[n]) credit[n] <= credit[n] - CRED_W'(1);
      end
    end
  end

  assign busy = pkt_valid | (|cred_nz);

endmodule
